// File: rtl/regfile_sb_pkg.sv
// regfile_sb_pkg: shared constants, types and the write-port priority
// resolver for the regfile_sb register file.
package regfile_sb_pkg;

  // Read latency selections for the RD_LAT parameter.
  localparam int RD_LAT_COMB = 0;
  localparam int RD_LAT_REG  = 1;

  // The resolver works on a fixed-width match vector; the top zero-extends
  // its N_WPORTS match bits into it, so up to MAX_WPORTS write ports work.
  localparam int MAX_WPORTS  = 8;
  localparam int WPORT_IDX_W = $clog2(MAX_WPORTS);

  // Winning write port for one register: hit = some port writes it,
  // port = index of the highest-numbered port that does.
  typedef struct packed {
    logic                   hit;
    logic [WPORT_IDX_W-1:0] port;
  } wport_sel_t;

  // Later iterations overwrite earlier ones, so the highest index wins.
  function automatic wport_sel_t wport_winner(input logic [MAX_WPORTS-1:0] match);
    wport_sel_t sel;
    sel = '0;
    for (int p = 0; p < MAX_WPORTS; p++) begin
      if (match[p]) begin
        sel.hit  = 1'b1;
        sel.port = WPORT_IDX_W'(p);
      end
    end
    return sel;
  endfunction

endpackage

// File: rtl/regfile_sb_register_en_rst.sv
// register_en_rst: WIDTH-bit register with load enable and asynchronous
// active-high reset to RST_VAL. One instance per architectural register.
module register_en_rst #(
  parameter int               WIDTH   = 32,
  parameter logic [WIDTH-1:0] RST_VAL = '0
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             en,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  // Hold the stored value; load d when enabled.
  // NOTE: sequential state uses non-blocking (<=) so every flop samples the
  // pre-edge values of its inputs regardless of block evaluation order.
  always_ff @(posedge clk or posedge rst) begin
    if (rst)     q <= RST_VAL;
    else if (en) q <= d;
  end

endmodule

// File: rtl/regfile_sb.sv
// regfile_sb: multi-port register file with highest-port-wins write
// arbitration, optional hard-wired zero register, selectable read latency
// and a per-register busy scoreboard (reserve sets, writeback clears,
// reserve wins on a same-cycle collision).
// Build option: define REGFILE_SB_BYPASS_EN to forward same-cycle write data
// (and the resulting busy state) onto matching read ports.
module regfile_sb
  import regfile_sb_pkg::*;
#(
  parameter int               WIDTH     = 32,
  parameter int               N_REG     = 32,
  parameter int               N_RPORTS  = 2,
  parameter int               N_WPORTS  = 1,
  parameter int               ZERO_REG  = 1,
  parameter logic [WIDTH-1:0] RESET_VAL = '0,
  parameter int               RD_LAT    = RD_LAT_COMB,
  parameter int               AW        = (N_REG > 1) ? $clog2(N_REG) : 1
) (
  input  logic                               clk,
  input  logic                               rst,
  input  logic [N_RPORTS-1:0][AW-1:0]        raddr,
  output logic [N_RPORTS-1:0][WIDTH-1:0]     rdata,
  output logic [N_RPORTS-1:0]                rbusy,
  input  logic [N_WPORTS-1:0][AW-1:0]        waddr,
  input  logic [N_WPORTS-1:0]                wen,
  input  logic [N_WPORTS-1:0][WIDTH-1:0]     wdata,
  input  logic                               rsv_en,
  input  logic [AW-1:0]                      rsv_addr,
  output logic [N_REG-1:0]                   busy
);

  // Register 0 has no storage when it is hard-wired to zero; the storage
  // arrays start at FIRST_REG so no dead bits exist in that configuration.
  localparam int FIRST_REG = (ZERO_REG != 0) ? 1 : 0;

  logic [N_REG-1:FIRST_REG][WIDTH-1:0] reg_q;
  logic [N_REG-1:FIRST_REG][WIDTH-1:0] reg_d;
  logic [N_REG-1:0]                    reg_we;
  logic [N_REG-1:0]                    rsv_hit;
  logic [N_REG-1:0]                    busy_d;
  logic [MAX_WPORTS-1:0]               wmatch;
  wport_sel_t                          wsel;

  logic [N_RPORTS-1:0][WIDTH-1:0]      rdata_c;
  logic [N_RPORTS-1:0]                 rbusy_c;

  // Per register: resolve which write port (if any) lands, and whether the
  // reserve port targets it. Addresses >= N_REG never match any register.
  // NOTE: every variable written here gets a default first, so no path
  // through the loops can leave one unassigned and infer a latch.
  always_comb begin
    reg_we  = '0;
    reg_d   = '0;
    rsv_hit = '0;
    wmatch  = '0;
    wsel    = '0;
    for (int r = FIRST_REG; r < N_REG; r++) begin
      wmatch = '0;
      for (int p = 0; p < N_WPORTS; p++) begin
        wmatch[p] = wen[p] && (waddr[p] == AW'(r));
      end
      wsel      = wport_winner(wmatch);
      reg_we[r] = wsel.hit;
      for (int p = 0; p < N_WPORTS; p++) begin
        if (wsel.port == WPORT_IDX_W'(p)) reg_d[r] = wdata[p];
      end
      rsv_hit[r] = rsv_en && (rsv_addr == AW'(r));
    end
  end

  // Storage: one enabled flop per architectural register.
  // NOTE: these flops take RESET_VAL on reset; that is only possible because
  // the file is built from flops rather than an inferred RAM macro.
  for (genvar r = FIRST_REG; r < N_REG; r++) begin : g_reg
    register_en_rst #(
      .WIDTH   (WIDTH),
      .RST_VAL (RESET_VAL)
    ) u_reg (
      .clk (clk),
      .rst (rst),
      .en  (reg_we[r]),
      .d   (reg_d[r]),
      .q   (reg_q[r])
    );
  end

  // Reserve sets, a write clears, and reserve wins when both hit.
  // reg_we[0] and rsv_hit[0] stay 0 with a zero register, so busy[0] stays 0.
  assign busy_d = rsv_hit | (busy & ~reg_we);

  // Scoreboard flops, exposed directly on the busy port.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_d;
  end

  // Combinational read view per port; invalid and zero-register reads give 0.
  always_comb begin
    rdata_c = '0;
    rbusy_c = '0;
    for (int j = 0; j < N_RPORTS; j++) begin
      for (int r = FIRST_REG; r < N_REG; r++) begin
        if (raddr[j] == AW'(r)) begin
`ifdef REGFILE_SB_BYPASS_EN
          if (reg_we[r]) begin
            rdata_c[j] = reg_d[r];
            rbusy_c[j] = rsv_hit[r];
          end else
`endif
          begin
            rdata_c[j] = reg_q[r];
            rbusy_c[j] = busy[r];
          end
        end
      end
    end
  end

  // Output stage: pass the read view through, or register it for RD_LAT=1.
  if (RD_LAT == RD_LAT_REG) begin : g_rd_reg
    // Capture the read view at each edge; cleared on reset.
    always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
        rdata <= '0;
        rbusy <= '0;
      end else begin
        rdata <= rdata_c;
        rbusy <= rbusy_c;
      end
    end
  end else begin : g_rd_comb
    assign rdata = rdata_c;
    assign rbusy = rbusy_c;
  end

endmodule

// File: tb/tb_regfile_sb.sv
// tb_regfile_sb: directed, table-driven bench for regfile_sb.
// dut_a: 32 regs, 2 read / 2 write ports, zero register, combinational read,
//        non-zero RESET_VAL. dut_b: 12 regs (non power of two), 1 write port,
//        no zero register, registered read.
module tb_regfile_sb;
  import regfile_sb_pkg::*;

  localparam logic [31:0] RV_A = 32'hC0DE_0001;
`ifdef REGFILE_SB_BYPASS_EN
  localparam bit BYPASS = 1'b1;
`else
  localparam bit BYPASS = 1'b0;
`endif

  logic clk, rst;

  logic [1:0][4:0]  raddr_a;
  logic [1:0][31:0] rdata_a;
  logic [1:0]       rbusy_a;
  logic [1:0][4:0]  waddr_a;
  logic [1:0]       wen_a;
  logic [1:0][31:0] wdata_a;
  logic             rsv_en_a;
  logic [4:0]       rsv_addr_a;
  logic [31:0]      busy_a;

  logic [1:0][3:0]  raddr_b;
  logic [1:0][31:0] rdata_b;
  logic [1:0]       rbusy_b;
  logic [0:0][3:0]  waddr_b;
  logic [0:0]       wen_b;
  logic [0:0][31:0] wdata_b;
  logic             rsv_en_b;
  logic [3:0]       rsv_addr_b;
  logic [11:0]      busy_b;

  regfile_sb #(
    .WIDTH(32), .N_REG(32), .N_RPORTS(2), .N_WPORTS(2), .ZERO_REG(1),
    .RESET_VAL(RV_A), .RD_LAT(RD_LAT_COMB)
  ) dut_a (
    .clk(clk), .rst(rst), .raddr(raddr_a), .rdata(rdata_a), .rbusy(rbusy_a),
    .waddr(waddr_a), .wen(wen_a), .wdata(wdata_a),
    .rsv_en(rsv_en_a), .rsv_addr(rsv_addr_a), .busy(busy_a)
  );

  regfile_sb #(
    .WIDTH(32), .N_REG(12), .N_RPORTS(2), .N_WPORTS(1), .ZERO_REG(0),
    .RESET_VAL(32'h0), .RD_LAT(RD_LAT_REG)
  ) dut_b (
    .clk(clk), .rst(rst), .raddr(raddr_b), .rdata(rdata_b), .rbusy(rbusy_b),
    .waddr(waddr_b), .wen(wen_b), .wdata(wdata_b),
    .rsv_en(rsv_en_b), .rsv_addr(rsv_addr_b), .busy(busy_b)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic        we0;
    logic [4:0]  wa0;
    logic [31:0] wd0;
    logic        we1;
    logic [4:0]  wa1;
    logic [31:0] wd1;
    logic        rsv;
    logic [4:0]  ra;
    logic [4:0]  chk;
    logic [31:0] exp_data;
    logic        exp_busy;
  } vec_t;

  vec_t vecs [12];

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    //           we0   wa0    wd0            we1   wa1    wd1            rsv   ra     chk    exp_data       exp_busy
    vecs[0]  = '{1'b1, 5'd5,  32'hDEADBEEF, 1'b1, 5'd5,  32'h12345678, 1'b0, 5'd0,  5'd5,  32'h12345678, 1'b0};
    vecs[1]  = '{1'b1, 5'd0,  32'hFFFFFFFF, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd0,  32'h0,        1'b0};
    vecs[2]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd0,  5'd0,  32'h0,        1'b0};
    vecs[3]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  5'd7,  RV_A,         1'b1};
    vecs[4]  = '{1'b1, 5'd7,  32'h00000077, 1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd7,  32'h00000077, 1'b0};
    vecs[5]  = '{1'b0, 5'd0,  32'h0,        1'b1, 5'd7,  32'h00000088, 1'b1, 5'd7,  5'd7,  32'h00000088, 1'b1};
    vecs[6]  = '{1'b1, 5'd10, 32'h0000AAAA, 1'b1, 5'd11, 32'h0000BBBB, 1'b0, 5'd0,  5'd10, 32'h0000AAAA, 1'b0};
    vecs[7]  = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  5'd11, 32'h0000BBBB, 1'b0};
    vecs[8]  = '{1'b1, 5'd12, 32'h0000CCCC, 1'b0, 5'd0,  32'h0,        1'b1, 5'd11, 5'd11, 32'h0000BBBB, 1'b1};
    vecs[9]  = '{1'b1, 5'd11, 32'h00001111, 1'b0, 5'd11, 32'h0000DEAD, 1'b0, 5'd0,  5'd11, 32'h00001111, 1'b0};
    vecs[10] = '{1'b0, 5'd0,  32'h0,        1'b0, 5'd0,  32'h0,        1'b1, 5'd31, 5'd31, RV_A,         1'b1};
    vecs[11] = '{1'b1, 5'd31, 32'h00000031, 1'b1, 5'd30, 32'h00000030, 1'b0, 5'd0,  5'd31, 32'h00000031, 1'b0};

    rst = 1'b1;
    raddr_a = '0; waddr_a = '0; wen_a = '0; wdata_a = '0; rsv_en_a = 1'b0; rsv_addr_a = '0;
    raddr_b = '0; waddr_b = '0; wen_b = '0; wdata_b = '0; rsv_en_b = 1'b0; rsv_addr_b = '0;

    // Reset state.
    repeat (2) @(posedge clk);
    #1;
    check("b rdata in reset", rdata_b[0], 32'h0);
    check("b rbusy in reset", rbusy_b[0], 32'h0);
    @(negedge clk);
    rst = 1'b0;
    for (int a = 0; a < 32; a++) begin
      raddr_a[0] = 5'(a);
      raddr_a[1] = 5'(a);
      #1;
      check($sformatf("reset r%0d p0", a), rdata_a[0], (a == 0) ? 32'h0 : RV_A);
      check($sformatf("reset r%0d p1", a), rdata_a[1], (a == 0) ? 32'h0 : RV_A);
      check($sformatf("reset rbusy r%0d", a), rbusy_a[0], 32'h0);
    end
    check("reset busy_a", busy_a, 32'h0);
    check("reset busy_b", busy_b, 32'h0);
    tick();

    // Table-driven single-cycle operations on dut_a.
    for (int i = 0; i < 12; i++) begin
      wen_a      = {vecs[i].we1, vecs[i].we0};
      waddr_a[0] = vecs[i].wa0;
      wdata_a[0] = vecs[i].wd0;
      waddr_a[1] = vecs[i].wa1;
      wdata_a[1] = vecs[i].wd1;
      rsv_en_a   = vecs[i].rsv;
      rsv_addr_a = vecs[i].ra;
      tick();
      wen_a      = '0;
      rsv_en_a   = 1'b0;
      raddr_a[0] = vecs[i].chk;
      raddr_a[1] = vecs[i].chk;
      #1;
      check($sformatf("vec%0d rdata0", i), rdata_a[0], vecs[i].exp_data);
      check($sformatf("vec%0d rdata1", i), rdata_a[1], vecs[i].exp_data);
      check($sformatf("vec%0d rbusy0", i), rbusy_a[0], vecs[i].exp_busy);
      check($sformatf("vec%0d busy", i), busy_a[vecs[i].chk], vecs[i].exp_busy);
    end

    // Same-cycle write and read of r3 (forwarding depends on the build).
    wen_a = 2'b01; waddr_a[0] = 5'd3; wdata_a[0] = 32'h000000A5;
    raddr_a[0] = 5'd3;
    #1;
    check("same-cycle read r3", rdata_a[0], BYPASS ? 32'h000000A5 : RV_A);
    check("same-cycle rbusy r3", rbusy_a[0], 32'h0);
    tick();
    wen_a = '0;
    #1;
    check("next-cycle read r3", rdata_a[0], 32'h000000A5);

    // Same-cycle write + reserve + read of r3.
    wen_a = 2'b01; wdata_a[0] = 32'h0000005A;
    rsv_en_a = 1'b1; rsv_addr_a = 5'd3;
    #1;
    check("wr+rsv read r3", rdata_a[0], BYPASS ? 32'h0000005A : 32'h000000A5);
    check("wr+rsv rbusy r3", rbusy_a[0], BYPASS ? 32'h1 : 32'h0);
    tick();
    wen_a = '0; rsv_en_a = 1'b0;
    #1;
    check("wr+rsv after r3", rdata_a[0], 32'h0000005A);
    check("wr+rsv busy r3", busy_a[3], 32'h1);

    // Registered read on dut_b: capture at edge, hold for a full cycle.
    wen_b = 1'b1; waddr_b[0] = 4'd9; wdata_b[0] = 32'h00000099;
    raddr_b[0] = 4'd0;
    tick();
    wen_b = 1'b0;
    raddr_b[0] = 4'd9;
    #1;
    check("b lat1 old capture", rdata_b[0], 32'h0);
    tick();
    check("b lat1 r9", rdata_b[0], 32'h00000099);
    raddr_b[0] = 4'd4;
    @(negedge clk);
    check("b lat1 hold r9", rdata_b[0], 32'h00000099);
    tick();
    check("b lat1 r4", rdata_b[0], 32'h0);

    // Reserve on dut_b shows up on registered rbusy.
    rsv_en_b = 1'b1; rsv_addr_b = 4'd2;
    tick();
    rsv_en_b = 1'b0;
    raddr_b[1] = 4'd2;
    tick();
    check("b rbusy r2", rbusy_b[1], 32'h1);
    check("b busy r2", busy_b[2], 32'h1);

    // Address N_REG on dut_b: reads 0, write and reserve have no effect.
    wen_b = 1'b1; waddr_b[0] = 4'd12; wdata_b[0] = 32'h0000EEEE;
    rsv_en_b = 1'b1; rsv_addr_b = 4'd12;
    raddr_b[0] = 4'd12;
    tick();
    wen_b = 1'b0; rsv_en_b = 1'b0;
    check("b oob rdata", rdata_b[0], 32'h0);
    check("b oob rbusy", rbusy_b[0], 32'h0);
    check("b oob busy", busy_b, 32'h004);
    raddr_b[0] = 4'd4;
    tick();
    check("b oob no alias r4", rdata_b[0], 32'h0);
    raddr_b[0] = 4'd0;
    tick();
    check("b oob no alias r0", rdata_b[0], 32'h0);

    // Asynchronous reset mid-cycle after writes and reserves.
    raddr_b[0] = 4'd9;
    raddr_a[0] = 5'd5;
    tick();
    check("pre-reset a r5", rdata_a[0], 32'h12345678);
    check("pre-reset b r9", rdata_b[0], 32'h00000099);
    wen_a = 2'b10; waddr_a[1] = 5'd5; wdata_a[1] = 32'h55555555;
    rsv_en_a = 1'b1; rsv_addr_a = 5'd5;
    #2;
    rst = 1'b1;
    #1;
    check("async reset a r5", rdata_a[0], RV_A);
    check("async reset busy_a", busy_a, 32'h0);
    check("async reset b rdata", rdata_b[0], 32'h0);
    check("async reset busy_b", busy_b, 32'h0);
    wen_a = '0; rsv_en_a = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    tick();
    check("post-reset a r5", rdata_a[0], RV_A);
    check("post-reset busy a r5", busy_a[5], 32'h0);
    check("post-reset b r9", rdata_b[0], 32'h0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/regfile_sb.md
# regfile_sb

Parametrised multi-port register file with asynchronous reset, deterministic write-port arbitration, an optional hard-wired zero register, selectable read latency and a per-register busy scoreboard. It is the general successor to the plain register-file block. It sits in the core's operand-fetch stage: issue logic reserves destination registers, and writeback ports retire them.

## Interface
Parameters:
- WIDTH, 32, bits per register
- N_REG, 32, number of registers (need not be a power of two; AW = $clog2(N_REG))
- N_RPORTS, 2, read ports
- N_WPORTS, 1, write ports
- ZERO_REG, 1, 1 = register 0 reads as 0, ignores writes and never becomes busy
- RESET_VAL, 0, value loaded into every register on reset
- RD_LAT, 0, read latency: 0 = combinational, 1 = registered

Ports:
- clk  in  1  clock; all state updates on rising edge
- rst  in  1  asynchronous, active-high reset
- raddr  in  [N_RPORTS][AW]  read addresses
- rdata  out  [N_RPORTS][WIDTH]  read data
- rbusy  out  [N_RPORTS]  busy flag of the read address, aligned with rdata
- waddr  in  [N_WPORTS][AW]  write addresses
- wen  in  [N_WPORTS]  write enables
- wdata  in  [N_WPORTS][WIDTH]  write data
- rsv_en  in  1  reserve (set busy) request
- rsv_addr  in  [AW]  register to reserve
- busy  out  [N_REG]  scoreboard, one bit per register

## Operation
- Write: if wen[p] is high at an edge, the register at waddr[p] takes wdata[p]. If several ports hit the same address, the highest-index port wins.
- Writes to register 0 (when ZERO_REG=1) are dropped. Writes to addresses ≥ N_REG are dropped.
- Read: rdata[j] = reg[raddr[j]]. Address 0 with ZERO_REG=1, or any address ≥ N_REG, reads 0 with rbusy 0.
- Scoreboard, evaluated per register at each edge:
  - A write from any port clears busy.
  - rsv_en sets busy[rsv_addr].
  - Reserve and write to the same register in the same cycle: data is written and busy ends at 1 (reserve wins).
  - Reserves to register 0 (ZERO_REG=1) or to addresses ≥ N_REG are ignored.
- All read ports are independent; any number may read the same address.

## Timing
- Reset: all registers = RESET_VAL, busy = 0, registered rdata/rbusy (RD_LAT=1) = 0. Reset is asynchronous and takes effect immediately, mid-cycle included. Pending writes and reserves in that cycle are lost.
- Write latency: a value written at edge N is readable (RD_LAT=0) from just after edge N.
- RD_LAT=0: rdata/rbusy are combinational from raddr and state.
- RD_LAT=1: raddr is sampled at edge N, and rdata/rbusy are valid after edge N and held until edge N+1. The captured value is the combinational view at edge N, including bypass when enabled.
- busy is a direct flop output, updated at each edge per the rules above.

## Configuration
- REGFILE_SB_BYPASS_EN defined: write-to-read forwarding.
  - A read whose address matches an active write in the same cycle returns the winning port's wdata.
  - rbusy for that read is 0, unless rsv_addr reserves the same register in that cycle, in which case rbusy is 1.
- Not defined: a same-cycle read returns the old register value and old busy. The new value is visible the cycle after the edge.

## Structure
- Package regfile_sb_pkg holds:
  - function `wport_winner`: priority resolver returning the highest-index matching port and a hit flag
  - constants RD_LAT_COMB = 0 and RD_LAT_REG = 1
- One sub-module, register_en_rst: a WIDTH-bit enabled flop with asynchronous active-high reset to a parameter value. It is instantiated N_REG times, or N_REG-1 times when ZERO_REG=1.
- Scoreboard and read muxes stay in the top level.

## Test plan
- Reset, then read every register on all ports → RESET_VAL everywhere, busy = 0. Assert rst mid-run after writes → immediate return to RESET_VAL.
- Write 0xDEADBEEF to r5 via port 0 and 0x12345678 to r5 via port 1 in one cycle (N_WPORTS=2) → r5 = 0x12345678.
- Write 0xFFFF_FFFF to r0 with ZERO_REG=1 → reads 0. Reserve r0 → busy[0] stays 0.
- rsv_en on r7 → busy[7] = 1 next cycle. Write r7 → busy[7] = 0. Reserve and write r7 in the same cycle → busy[7] = 1, data updated.
- Same-cycle write 0xA5 and read r3 with RD_LAT=0:
  - with REGFILE_SB_BYPASS_EN → 0xA5 immediately
  - without → old value, then 0xA5 next cycle
- RD_LAT=1: raddr=r9 at edge N → rdata = reg9 after edge N, stable until N+1. Address N_REG on a non-power-of-two N_REG → 0, no side effects.
